// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding, frame geometry, held-byte record.
// Shared by the transmitter and the receiver side.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        logic                      stop_err;
    } uart_frame_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte source handshake: tx_data/tx_stop_err offered with tx_valid,
// taken by the sink while tx_ready (holding register empty) is high.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_stop_err;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_stop_err,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_stop_err,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; o_bit_end marks the
// last cycle of a bit; i_clear restarts the count synchronously.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    assign o_bit_end = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless frames.
// Ports: CLK, reset (async low), tx_if (slave handshake), data_out, busy, tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic     CLK,
    input  logic     reset,
    uart_tx_if.slave tx_if,
    output logic     data_out,
    output logic     busy,
    output logic     tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]  r_state;
    uart_frame_t r_hold;
    logic        r_hold_full;
    logic [7:0]  r_shift;
    logic        r_err;
    logic [2:0]  r_idx;
    logic        r_line;

    logic [1:0]  w_next;
    logic        w_line;
    logic        w_bit_end;
    logic        w_accept;
    logic        w_load;
    logic        w_shift;

    // Counter idles at zero, so the first START cycle is count 0;
    // every later state entry lands on a natural wrap.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (CLK),
        .i_rst_n  (reset),
        .i_clear  (r_state == ST_IDLE),
        .o_bit_end(w_bit_end)
    );

    assign tx_if.tx_ready = ~r_hold_full;
    assign data_out       = r_line;
    assign busy           = (r_state != ST_IDLE);
    assign tx_done        = (r_state == ST_STOP) && w_bit_end;

    assign w_accept = tx_if.tx_valid && ~r_hold_full;
    assign w_load   = r_hold_full &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_STOP) && w_bit_end));
    assign w_shift  = w_bit_end &&
                      ((r_state == ST_START) || (r_state == ST_DATA));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_hold_full) w_next = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_idx == LAST_BIT)) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_next = r_hold_full ? ST_START : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Line value for the next cycle; in DATA it only changes at a bit
    // boundary, taking the LSB that the shifter has exposed.
    always_comb begin
        w_line = r_line;
        unique case (w_next)
            ST_IDLE:  w_line = 1'b1;
            ST_START: w_line = 1'b0;
            ST_DATA: begin
                if (w_bit_end) w_line = r_shift[0];
            end
            ST_STOP:  w_line = ~r_err;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_line      <= 1'b1;
        end else begin
            r_state <= w_next;
            r_line  <= w_line;

            if (w_accept) begin
                r_hold.data     <= tx_if.tx_data;
                r_hold.stop_err <= tx_if.tx_stop_err;
                r_hold_full     <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift <= r_hold.data;
                r_err   <= r_hold.stop_err;
            end else if (w_shift) begin
                r_shift <= r_shift >> 1;
            end

            if (r_state != ST_DATA) begin
                r_idx <= '0;
            end else if (w_bit_end) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timeline reference model plus
// directed literal checks and randomized traffic.
module tb_uart_tx;

    localparam int C     = 16;
    localparam int FRAME = 10 * C;
    localparam int LOGN  = 65536;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_if u_if ();
    logic data_out;
    logic busy;
    logic tx_done;

    uart_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .CLK     (CLK),
        .reset   (rst_n),
        .tx_if   (u_if.slave),
        .data_out(data_out),
        .busy    (busy),
        .tx_done (tx_done)
    );

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    int         q_start[$];
    logic [7:0] q_data[$];
    logic       q_err[$];

    bit line_log [0:LOGN-1];
    bit busy_log [0:LOGN-1];
    bit done_log [0:LOGN-1];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d n=%0d", name, got, exp, n);
        end
    endtask

    function automatic int last_end();
        if (q_start.size() == 0) return 0;
        return q_start[q_start.size()-1] + FRAME;
    endfunction

    // A byte is held (not ready) while the newest frame has not yet started.
    function automatic bit m_ready();
        if (q_start.size() == 0) return 1'b1;
        return q_start[q_start.size()-1] <= n;
    endfunction

    // Frame index covering cycle t, or -1 when the line is idle.
    function automatic int m_frame(input int t);
        int lo;
        lo = q_start.size() - 3;
        for (int i = q_start.size() - 1; i >= 0 && i >= lo; i--) begin
            if (t >= q_start[i] && t < q_start[i] + FRAME) return i;
        end
        return -1;
    endfunction

    function automatic bit m_line(input int t);
        int f;
        int p;
        logic [7:0] b;
        f = m_frame(t);
        if (f < 0) return 1'b1;
        p = (t - q_start[f]) / C;
        if (p == 0) return 1'b0;
        if (p == 9) return ~q_err[f];
        b = q_data[f];
        return b[p-1];
    endfunction

    function automatic bit m_done(input int t);
        int f;
        f = m_frame(t);
        if (f < 0) return 1'b0;
        return t == q_start[f] + FRAME - 1;
    endfunction

    task automatic step();
        bit acc;
        int s;
        logic [7:0] d;
        logic e;
        acc = u_if.tx_valid && rst_n && m_ready();
        d = u_if.tx_data;
        e = u_if.tx_stop_err;
        @(posedge CLK);
        n++;
        if (acc) begin
            s = (n + 1 > last_end()) ? n + 1 : last_end();
            q_start.push_back(s);
            q_data.push_back(d);
            q_err.push_back(e);
        end
        @(negedge CLK);
        if (n < LOGN) begin
            line_log[n] = data_out;
            busy_log[n] = busy;
            done_log[n] = tx_done;
        end
        check("data_out", data_out, m_line(n));
        check("busy", busy, m_frame(n) >= 0);
        check("tx_done", tx_done, m_done(n));
        check("tx_ready", u_if.tx_ready, m_ready());
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic send(input logic [7:0] d, input logic e, output int s);
        int sz;
        sz = q_start.size();
        u_if.tx_data     = d;
        u_if.tx_stop_err = e;
        u_if.tx_valid    = 1'b1;
        for (int k = 0; k < 4 * FRAME && q_start.size() == sz; k++) step();
        u_if.tx_valid = 1'b0;
        check("send_accepted", q_start.size(), sz + 1);
        s = (q_start.size() > sz) ? q_start[q_start.size()-1] : 0;
    endtask

    function automatic int count_ones(input int a, input int b, input int which);
        int c;
        c = 0;
        for (int t = a; t < b; t++) begin
            if (t >= 0 && t < LOGN) begin
                if (which == 0 && line_log[t]) c++;
                if (which == 1 && busy_log[t]) c++;
                if (which == 2 && done_log[t]) c++;
            end
        end
        return c;
    endfunction

    int s;
    int s1;
    int s2;
    int t0;
    logic [9:0] exp_bits;

    initial begin
        u_if.tx_valid    = 1'b0;
        u_if.tx_data     = 8'h00;
        u_if.tx_stop_err = 1'b0;
        rst_n            = 1'b0;

        run(3);
        check("rst_data_out", data_out, 1);
        check("rst_tx_ready", u_if.tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        rst_n = 1'b1;
        run(2);

        send(8'hA5, 1'b0, s);
        run(11 * C);
        exp_bits = 10'b1101001010;
        check("a5_pre_start", line_log[s-1], 1);
        for (int i = 0; i < 10; i++)
            check("a5_bit", line_log[s + C/2 + i*C], exp_bits[i]);
        check("a5_done_pos", done_log[s + FRAME - 1], 1);
        check("a5_done_count", count_ones(s - 1, s + FRAME + C, 2), 1);
        check("a5_busy_last", busy_log[s + FRAME - 1], 1);
        check("a5_busy_fall", busy_log[s + FRAME], 0);

        send(8'h00, 1'b0, s1);
        send(8'hFF, 1'b0, s2);
        run(22 * C);
        check("b2b_gap", s2 - s1, FRAME);
        check("b2b_stop_hi", line_log[s1 + FRAME - 1], 1);
        check("b2b_start_lo", line_log[s1 + FRAME], 0);
        check("b2b_busy_span", count_ones(s1, s1 + 2*FRAME, 1), 2 * FRAME);
        check("b2b_busy_fall", busy_log[s1 + 2*FRAME], 0);
        check("b2b_done_count", count_ones(s1, s1 + 2*FRAME, 2), 2);

        send(8'h55, 1'b1, s);
        run(11 * C);
        check("err_stop_low", count_ones(s + 9*C, s + FRAME, 0), 0);
        check("err_done", done_log[s + FRAME - 1], 1);
        check("err_after_hi", line_log[s + FRAME], 1);

        send(8'h3C, 1'b0, s);
        while (n < s + 4*C + C/2 && n < s + FRAME) step();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_line", data_out, 1);
        check("mid_rst_ready", u_if.tx_ready, 1);
        check("mid_rst_busy", busy, 0);
        q_start.delete();
        q_data.delete();
        q_err.delete();
        run(3);
        rst_n = 1'b1;
        run(2);
        send(8'h81, 1'b0, s);
        run(11 * C);
        exp_bits = 10'b1100000010;
        for (int i = 0; i < 10; i++)
            check("x81_bit", line_log[s + C/2 + i*C], exp_bits[i]);

        for (int i = 0; i < 6000; i++) begin
            u_if.tx_valid    = ($urandom_range(0, 3) == 0);
            u_if.tx_data     = 8'($urandom);
            u_if.tx_stop_err = ($urandom_range(0, 7) == 0);
            step();
        end
        u_if.tx_valid = 1'b0;
        run(2 * FRAME + 4);

        t0 = n + 1;
        run(5000);
        check("stall_busy", count_ones(t0, t0 + 5000, 1), 0);
        check("stall_line", count_ones(t0, t0 + 5000, 0), 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drives the line consumed by `UART_RX_top`. It takes bytes from a parallel valid/ready source and emits 8N1 frames: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1). A one-byte holding register lets the source queue the next byte while the current frame shifts out, so frames can be sent back-to-back. A per-byte stop-bit error injection input lets benches exercise the receiver's framing-error path.

## Interface
- `CLKS_PER_BIT`, default 100: clock cycles per bit (10 ns clock, 1000 ns bit). Legal values are ≥ 16.
- `CLK` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to send.
- `tx_stop_err` input 1: sampled with `tx_data`; when 1, that frame's stop bit is driven 0.
- `tx_valid` input 1: the source offers `tx_data` and `tx_stop_err`.
- `tx_ready` output 1: the holding register is empty.
- `data_out` output 1: serial line, registered, idle high.
- `busy` output 1: a frame is in progress (FSM not in IDLE).
- `tx_done` output 1: one-cycle pulse in the last cycle of each stop bit.

## Operation
- **Handshake**
  - A transfer occurs on a rising edge where `tx_valid && tx_ready`.
  - The byte and its error flag are latched into the holding register, and `hold_full` is set.
  - `tx_ready = ~hold_full`, a combinational function of register state only. It does not depend on `tx_valid`.
- **FSM states: IDLE, START, DATA, STOP**
  - IDLE → START when `hold_full`. On that edge the shifter and error flag load from the holding register and `hold_full` clears.
  - START → DATA when the baud counter reaches `CLKS_PER_BIT-1`.
  - DATA → STOP after bit index 7 completes. The shifter shifts right once per bit, and `data_out` takes `shift[0]`.
  - STOP → START if `hold_full` at the end of the stop bit. The holding register loads directly into the shifter, with no idle gap. Otherwise STOP → IDLE.
- **Line level per state**
  - IDLE: 1.
  - START: 0.
  - DATA: the current data bit.
  - STOP: `~err_flag`.
- **Counters**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT-1`, wraps to 0, and resets to 0 on every state entry.
  - The bit index is 3 bits wide, 0..7, and is used only in DATA.
- **Simultaneous events**
  - A handshake in the same cycle that the holding register drains is impossible, because `tx_ready` was 0 that cycle.
  - A handshake in the cycle after draining is accepted normally.
- **Reset values**
  - `data_out` = 1, `tx_ready` = 1, `busy` = 0, `tx_done` = 0.
  - FSM = IDLE, counters = 0, `hold_full` = 0.
- **Reset mid-frame**
  - The line returns high immediately (asynchronously).
  - The in-flight byte and any held byte are discarded.
  - Operation resumes normally after deassertion.

## Timing
- **Latency from IDLE**
  - A byte accepted at edge k moves the FSM to START at edge k+1.
  - `data_out` falls right after edge k+1.
- **Frame length**
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - A frame lasts `10*CLKS_PER_BIT` cycles (1000 cycles at the default).
- **`tx_done`** is high during cycle `10*CLKS_PER_BIT` of the frame, counted from the START entry. It pulses even when the stop bit was error-injected.
- **Back-to-back frames**: the next start bit begins on the cycle immediately after the stop bit's last cycle.
- **`tx_ready` timing**
  - `tx_ready` returns to 1 one cycle after the IDLE→START or STOP→START load.
  - A second byte can therefore be queued roughly one cycle into the current frame.
- **Glitch-free output**: `data_out` is driven directly from a flop, so it cannot glitch.

## Structure
- **`uart_pkg`**
  - FSM state encoding.
  - `UART_DATA_BITS = 8`.
  - `UART_DEFAULT_CLKS_PER_BIT = 100`.
  - `uart_pkg` is shared with the RX side.
- **`uart_baud_gen`** (sub-module): a parameterized counter with a synchronous `clear` input and a `bit_end` output pulse. It is reusable by `UART_RX_top` for its 16x oversampling tick.
- **`uart_tx`**: contains the holding register, shifter, and FSM.

## Test plan
- **Single byte**: send 0xA5 from idle. `data_out` must read 0 (start), then 1,0,1,0,0,1,0,1, then 1, sampled mid-bit every 100 cycles. `tx_done` pulses once, and `busy` falls the following cycle.
- **Back-to-back**: queue 0x00 then 0xFF with `tx_valid` held high. The second start bit follows the first stop bit with zero idle cycles. There are 2000 cycles from the first start bit to `busy` falling, and `tx_ready` is never high while a byte is held.
- **Error injection**: send 0x55 with `tx_stop_err` = 1. The stop bit is low for 100 cycles, `tx_done` still pulses, and `UART_RX_top` asserts `error`.
- **Reset mid-frame**: assert reset during DATA bit 3 of 0x3C. `data_out` goes 1 within the same cycle and `tx_ready` goes 1. After release, sending 0x81 produces a clean frame.
- **Loopback**: connect `data_out` to `UART_RX_top.data_in`. Send bytes 0..14. `error` stays 0, and the FIFO read-out via `display_next` returns 0x00..0x0E in order on `data_out_msd`/`data_out_lsd`.
- **Stall**: hold `tx_valid` = 0 for 5000 cycles after a frame. `data_out` stays 1, `busy` stays 0, and the FSM remains in IDLE.
